// File: rtl/isa_pkg.sv
// Shared ISA definitions: word geometry, opcode map, field positions and
// the instruction format classifier.
package isa_pkg;

    localparam int INSTR_W = 32;
    localparam int OPC_W   = 6;
    localparam int REG_W   = 5;
    localparam int IMM_W   = 16;

    localparam logic [OPC_W-1:0] OPC_LI      = 6'h00;
    localparam logic [OPC_W-1:0] OPC_MOV     = 6'h01;
    localparam logic [OPC_W-1:0] OPC_LD      = 6'h02;
    localparam logic [OPC_W-1:0] OPC_ST      = 6'h03;
    localparam logic [OPC_W-1:0] OPC_R_FIRST = 6'h04;
    localparam logic [OPC_W-1:0] OPC_R_LAST  = 6'h10;

    localparam int OPC_LSB      = 26;
    localparam int OPC_MSB      = 31;
    localparam int RDST2_LSB    = 21;
    localparam int RDST2_MSB    = 25;
    localparam int RDST1_LSB    = 16;
    localparam int RDST1_MSB    = 20;
    localparam int RSRC2_R_LSB  = 5;
    localparam int RSRC2_R_MSB  = 9;
    localparam int RSRC2_LSB    = 0;
    localparam int RSRC2_MSB    = 4;
    localparam int RSRC1_LSB    = 0;
    localparam int RSRC1_MSB    = 4;
    localparam int ADDR_DST_LSB = 18;
    localparam int ADDR_DST_MSB = 25;
    localparam int ADDR_SRC_LSB = 0;
    localparam int ADDR_SRC_MSB = 7;
    localparam int IMM_LSB      = 0;
    localparam int IMM_MSB      = 15;

    typedef enum logic [2:0] {
        FMT_LI,
        FMT_MOV,
        FMT_LD,
        FMT_ST,
        FMT_R,
        FMT_ILL
    } fmt_e;

    function automatic fmt_e decode_fmt(input logic [OPC_W-1:0] opc);
        if (opc == OPC_LI)                                return FMT_LI;
        else if (opc == OPC_MOV)                          return FMT_MOV;
        else if (opc == OPC_LD)                           return FMT_LD;
        else if (opc == OPC_ST)                           return FMT_ST;
        else if (opc >= OPC_R_FIRST && opc <= OPC_R_LAST) return FMT_R;
        else                                              return FMT_ILL;
    endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational encoder: places the instruction fields into a 32-bit word
// according to the opcode's format and flags opcodes outside the ISA.
module instr_field_pack
    import isa_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic [OPC_W-1:0]   opcode,
    input  logic [REG_W-1:0]   rdst2,
    input  logic [REG_W-1:0]   rdst1,
    input  logic [REG_W-1:0]   rsrc2,
    input  logic [REG_W-1:0]   rsrc1,
    input  logic [ADDR_W-1:0]  addr_src,
    input  logic [ADDR_W-1:0]  addr_dst,
    input  logic [IMM_W-1:0]   imm,
    output logic [INSTR_W-1:0] word,
    output logic               illegal
);

    fmt_e fmt;

    assign fmt     = decode_fmt(opcode);
    assign illegal = (fmt == FMT_ILL);

    always_comb begin
        // NOTE: word is zeroed before the case so every unassigned bit reads 0
        // and no path through the block leaves it unwritten (no latch).
        word                   = '0;
        word[OPC_MSB:OPC_LSB]  = opcode;
        unique case (fmt)
            FMT_LI: begin
                word[RDST2_MSB:RDST2_LSB] = rdst2;
                word[IMM_MSB:IMM_LSB]     = imm;
            end
            FMT_MOV: begin
                word[RDST2_MSB:RDST2_LSB] = rdst2;
                word[RSRC2_MSB:RSRC2_LSB] = rsrc2;
            end
            FMT_LD: begin
                word[RDST2_MSB:RDST2_LSB]     = rdst2;
                word[ADDR_SRC_LSB +: ADDR_W]  = addr_src;
            end
            FMT_ST: begin
                word[ADDR_DST_LSB +: ADDR_W]  = addr_dst;
                word[RSRC2_MSB:RSRC2_LSB]     = rsrc2;
            end
            FMT_R: begin
                word[RDST2_MSB:RDST2_LSB]     = rdst2;
                word[RDST1_MSB:RDST1_LSB]     = rdst1;
                word[RSRC2_R_MSB:RSRC2_R_LSB] = rsrc2;
                word[RSRC1_MSB:RSRC1_LSB]     = rsrc1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_encode_fifo.sv
// Instruction encoder feeding a first-word-fall-through buffer; illegal
// opcodes are swallowed and counted instead of stored.
module instr_encode_fifo
    import isa_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [OPC_W-1:0]             opcode,
    input  logic [REG_W-1:0]             rdst2,
    input  logic [REG_W-1:0]             rdst1,
    input  logic [REG_W-1:0]             rsrc2,
    input  logic [REG_W-1:0]             rsrc1,
    input  logic [ADDR_W-1:0]            addr_src,
    input  logic [ADDR_W-1:0]            addr_dst,
    input  logic [IMM_W-1:0]             imm,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [INSTR_W-1:0]           out_instr,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         illegal,
    output logic [7:0]                   illegal_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [INSTR_W-1:0] enc_word;
    logic               enc_illegal;
    logic               full;
    logic               accept;
    logic               push;
    logic               pop;

    instr_field_pack #(.ADDR_W(ADDR_W)) u_pack (
        .opcode   (opcode),
        .rdst2    (rdst2),
        .rdst1    (rdst1),
        .rsrc2    (rsrc2),
        .rsrc1    (rsrc1),
        .addr_src (addr_src),
        .addr_dst (addr_dst),
        .imm      (imm),
        .word     (enc_word),
        .illegal  (enc_illegal)
    );

    assign full      = (count == CNT_W'(DEPTH));
    assign in_ready  = !full && !flush;
    assign accept    = in_valid && in_ready;
    assign push      = accept && !enc_illegal;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign out_instr = mem[rd_ptr];

    // NOTE: all registered state uses non-blocking assignment so each flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Flush forces in_ready low, so no illegal accept can coincide with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal     <= 1'b0;
            illegal_cnt <= '0;
        end else begin
            illegal <= accept && enc_illegal;
            if (accept && enc_illegal && illegal_cnt != 8'hFF)
                illegal_cnt <= illegal_cnt + 8'd1;
        end
    end

    // NOTE: storage carries no reset; pointers and count alone define which
    // entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= enc_word;
    end

endmodule

// File: tb/tb_instr_encode_fifo.sv
// Scoreboard bench for instr_encode_fifo at DEPTH=4: directed vectors push
// expected words into a queue, a negedge monitor compares the FIFO head.
module tb_instr_encode_fifo;

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  d2, d1, s2, s1;
        logic [7:0]  as, ad;
        logic [15:0] im;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  opcode = '0;
    logic [4:0]  rdst2 = '0, rdst1 = '0, rsrc2 = '0, rsrc1 = '0;
    logic [7:0]  addr_src = '0, addr_dst = '0;
    logic [15:0] imm = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [2:0]  count;
    logic        illegal;
    logic [7:0]  illegal_cnt;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    instr_encode_fifo #(.DEPTH(4), .ADDR_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .opcode      (opcode),
        .rdst2       (rdst2),
        .rdst1       (rdst1),
        .rsrc2       (rsrc2),
        .rsrc1       (rsrc1),
        .addr_src    (addr_src),
        .addr_dst    (addr_dst),
        .imm         (imm),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .count       (count),
        .illegal     (illegal),
        .illegal_cnt (illegal_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] op, input logic [4:0] d2, input logic [4:0] d1,
                                input logic [4:0] s2, input logic [4:0] s1, input logic [7:0] as,
                                input logic [7:0] ad, input logic [15:0] im, input logic [31:0] exp);
        vec_t v;
        v.op = op; v.d2 = d2; v.d1 = d1; v.s2 = s2; v.s1 = s1;
        v.as = as; v.ad = ad; v.im = im; v.exp = exp;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        opcode = v.op; rdst2 = v.d2; rdst1 = v.d1; rsrc2 = v.s2; rsrc1 = v.s1;
        addr_src = v.as; addr_dst = v.ad; imm = v.im;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic do_push(input vec_t v, input bit legal);
        int n = 0;
        drive(v);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) check("push_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        if (legal && in_ready) exp_q.push_back(v.exp);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("drain_timeout", exp_q.size(), 0);
        @(negedge clk);
        check("count_after_drain", {29'd0, count}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares the head every cycle it is presented, pops on handshake.
    always @(negedge clk) begin
        if (!rst && !flush && out_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_unexpected: got %h, expected no output", out_instr);
            end else begin
                check(out_ready ? "out_instr_pop" : "out_instr_hold", out_instr, exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v_li, v_r, v_st, v_mov, v_ld, v_ill1, v_ill2, v_x;
        vec_t w[5];
        v_li   = mk(6'h00, 5'd3,  5'h1F, 5'h1F, 5'h1F, 8'hFF, 8'hFF, 16'h1234, 32'h00601234);
        v_r    = mk(6'h04, 5'd1,  5'd2,  5'd3,  5'd4,  8'hFF, 8'hFF, 16'hFFFF, 32'h10220064);
        v_st   = mk(6'h03, 5'h1F, 5'h1F, 5'd7,  5'h1F, 8'hFF, 8'hA5, 16'hFFFF, 32'h0E940007);
        v_mov  = mk(6'h01, 5'd5,  5'h1F, 5'd9,  5'h1F, 8'hFF, 8'hFF, 16'hFFFF, 32'h04A00009);
        v_ld   = mk(6'h02, 5'd31, 5'h1F, 5'h1F, 5'h1F, 8'h5A, 8'hFF, 16'hFFFF, 32'h0BE0005A);
        v_ill1 = mk(6'h11, 5'd1,  5'd2,  5'd3,  5'd4,  8'h11, 8'h22, 16'h3333, 32'h0);
        v_ill2 = mk(6'h3F, 5'd1,  5'd2,  5'd3,  5'd4,  8'h11, 8'h22, 16'h3333, 32'h0);
        v_x    = mk(6'h05, 5'd7,  5'd7,  5'd7,  5'd7,  8'h00, 8'h00, 16'h0000, 32'h14E700E7);
        w[0]   = mk(6'h05, 5'd1,  5'd2,  5'd3,  5'd4,  8'hFF, 8'hFF, 16'hFFFF, 32'h14220064);
        w[1]   = mk(6'h10, 5'd31, 5'd0,  5'd31, 5'd0,  8'hFF, 8'hFF, 16'hFFFF, 32'h43E003E0);
        w[2]   = mk(6'h00, 5'd0,  5'h1F, 5'h1F, 5'h1F, 8'hFF, 8'hFF, 16'hFFFF, 32'h0000FFFF);
        w[3]   = mk(6'h03, 5'h1F, 5'h1F, 5'd31, 5'h1F, 8'h00, 8'hFF, 16'hFFFF, 32'h0FFC001F);
        w[4]   = mk(6'h01, 5'd31, 5'h1F, 5'd1,  5'h1F, 8'hFF, 8'hFF, 16'hFFFF, 32'h07E00001);

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        check("rst_illegal_cnt", {24'd0, illegal_cnt}, 32'd0);
        @(posedge clk);
        #1;

        // Latency-1 LI, then each legal format with noise on unused fields
        out_ready = 1'b1;
        do_push(v_li, 1'b1);
        @(negedge clk);
        check("li_latency_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        do_push(v_r, 1'b1);
        do_push(v_st, 1'b1);
        do_push(v_mov, 1'b1);
        do_push(v_ld, 1'b1);
        wait_empty();

        // Illegal opcodes: pulse once, counted, never stored
        do_push(v_ill1, 1'b0);
        @(negedge clk);
        check("ill_pulse", {31'd0, illegal}, 32'd1);
        check("ill_cnt1", {24'd0, illegal_cnt}, 32'd1);
        check("ill_count", {29'd0, count}, 32'd0);
        check("ill_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("ill_pulse_end", {31'd0, illegal}, 32'd0);
        @(posedge clk);
        #1;
        do_push(v_ill2, 1'b0);
        @(negedge clk);
        check("ill_cnt2", {24'd0, illegal_cnt}, 32'd2);
        @(posedge clk);
        #1;

        // Full, hold, single pop, wrap
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) do_push(w[i], 1'b1);
        @(negedge clk);
        check("full_count", {29'd0, count}, 32'd4);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1 drive(w[4]);
        in_valid = 1'b1;
        @(negedge clk);
        check("full_held_count", {29'd0, count}, 32'd4);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("full_still_blocked", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("pop_in_ready", {31'd0, in_ready}, 32'd1);
        check("pop_count", {29'd0, count}, 32'd3);
        @(posedge clk);
        exp_q.push_back(w[4].exp);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("fifth_stored", {29'd0, count}, 32'd4);
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_empty();

        // Flush with count=3 and a push in the same cycle
        out_ready = 1'b0;
        do_push(v_r, 1'b1);
        do_push(v_st, 1'b1);
        do_push(v_mov, 1'b1);
        @(negedge clk);
        check("pre_flush_count", {29'd0, count}, 32'd3);
        @(posedge clk);
        #1 drive(v_x);
        in_valid = 1'b1;
        flush = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("flush_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        exp_q.delete();
        #1 flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_count", {29'd0, count}, 32'd0);
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_illegal_cnt", {24'd0, illegal_cnt}, 32'd2);
        @(posedge clk);
        #1;
        do_push(v_ld, 1'b1);
        wait_empty();

        // Mid-stream reset with count=2, illegal_cnt=5 and a live handshake
        out_ready = 1'b0;
        do_push(v_li, 1'b1);
        do_push(v_r, 1'b1);
        for (int i = 0; i < 3; i++) do_push(v_ill1, 1'b0);
        @(negedge clk);
        check("pre_rst_count", {29'd0, count}, 32'd2);
        check("pre_rst_illegal_cnt", {24'd0, illegal_cnt}, 32'd5);
        @(posedge clk);
        #1 drive(v_ill2);
        in_valid = 1'b1;
        out_ready = 1'b1;
        flush = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        exp_q.delete();
        #1 rst = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_count", {29'd0, count}, 32'd0);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_illegal", {31'd0, illegal}, 32'd0);
        check("mid_rst_illegal_cnt", {24'd0, illegal_cnt}, 32'd0);
        @(posedge clk);
        #1;

        // Pointers restart at zero: one word must come straight back out
        do_push(v_st, 1'b1);
        wait_empty();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
